// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK symbol mapper: FSM encoding, default word format
// and the saturating negation used to flip the carrier phase.
package bpsk_pkg;

    localparam int DEF_SYMBOL_WIDTH = 16;
    localparam int DEF_SYMBOL_FRAC  = 14;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Negate a w-bit signed value held sign-extended in 64 bits; the most negative
    // code has no positive counterpart and clips to the largest positive code.
    function automatic logic signed [63:0] neg_sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] lim;
        lim = 64'sd1 <<< (w - 1);
        if (x == -lim)
            return lim - 64'sd1;
        return -x;
    endfunction

endpackage

// File: rtl/bpsk_bit_fifo.sv
// Small 1-bit-wide FIFO buffering the serial bit stream ahead of the mapper.
// No empty bypass: a pushed bit becomes visible on dout the cycle after the push.
module bpsk_bit_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       din,
    input  logic                       pop,
    output logic                       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok)
            rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bpsk_symbol_mapper.sv
// BPSK mapper: holds each buffered bit for SPS carrier samples, +carrier for 0, -carrier for 1.
// Define BPSK_DIFF_ENCODE_EN to differentially encode bits as they leave the FIFO.
module bpsk_symbol_mapper
    import bpsk_pkg::*;
#(
    parameter int SYMBOL_WIDTH = DEF_SYMBOL_WIDTH,
    parameter int SYMBOL_FRAC  = DEF_SYMBOL_FRAC,
    parameter int SPS          = 6,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           new_sample,
    input  logic signed [SYMBOL_WIDTH-1:0] carrier_i,
    input  logic                           bit_data,
    input  logic                           bit_valid,
    output logic                           bit_ready,
    output logic signed [SYMBOL_WIDTH-1:0] sample,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           underrun
);
    localparam int CNT_W = $clog2(SPS);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    if (SPS < 2 || SYMBOL_FRAC >= SYMBOL_WIDTH) begin : g_cfg_check
        $error("bpsk_symbol_mapper: invalid SPS or SYMBOL_FRAC");
    end

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           cur_bit_q, cur_bit_d;
    logic signed [SYMBOL_WIDTH-1:0] sample_q, sample_d;
    logic                           sample_valid_q, sample_valid_d;
    logic                           underrun_q, underrun_d;
`ifdef BPSK_DIFF_ENCODE_EN
    logic                           diff_state_q, diff_state_d;
`endif

    logic           strobe, fifo_pop, fifo_push, fifo_dout, fifo_full, fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic           next_bit;

    assign bit_ready = (fifo_count != FCW'(FIFO_DEPTH));
    assign fifo_push = bit_valid && !fifo_full;
    assign strobe    = new_sample && en;

    bpsk_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (bit_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef BPSK_DIFF_ENCODE_EN
    assign next_bit = fifo_dout ^ diff_state_q;
`else
    assign next_bit = fifo_dout;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cur_bit_d      = cur_bit_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        underrun_d     = 1'b0;
        fifo_pop       = 1'b0;
`ifdef BPSK_DIFF_ENCODE_EN
        diff_state_d   = diff_state_q;
`endif
        if (strobe) begin
            sample_valid_d = 1'b1;
            if (state_q == IDLE) begin
                sample_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cnt_d    = '0;
                    state_d  = ACTIVE;
                end
            end else begin
                sample_d = cur_bit_q ? SYMBOL_WIDTH'(neg_sat(64'(carrier_i), SYMBOL_WIDTH))
                                     : carrier_i;
                if (cnt_q == CNT_W'(SPS - 1)) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        underrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Every pop, from either state, loads the next symbol bit.
            if (fifo_pop) begin
                cur_bit_d = next_bit;
`ifdef BPSK_DIFF_ENCODE_EN
                diff_state_d = next_bit;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cur_bit_q      <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
`ifdef BPSK_DIFF_ENCODE_EN
            diff_state_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cur_bit_q      <= cur_bit_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
`ifdef BPSK_DIFF_ENCODE_EN
            diff_state_q   <= diff_state_d;
`endif
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign underrun     = underrun_q;
    assign busy         = (state_q == ACTIVE);

endmodule

// File: tb/tb_bpsk_symbol_mapper.sv
// Directed bench for bpsk_symbol_mapper (SPS=6, FIFO_DEPTH=4); expected values hand-computed.
// Honours BPSK_DIFF_ENCODE_EN for the differential-encoding expectations.
module tb_bpsk_symbol_mapper;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic                new_sample = 1'b0;
    logic signed [W-1:0] carrier_i = 16'sd16384;
    logic                bit_data = 1'b0;
    logic                bit_valid = 1'b0;
    logic                bit_ready;
    logic signed [W-1:0] sample;
    logic                sample_valid;
    logic                busy;
    logic                underrun;

    int errors = 0;
    int checks = 0;

    bpsk_symbol_mapper #(
        .SYMBOL_WIDTH (16),
        .SYMBOL_FRAC  (14),
        .SPS          (6),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .new_sample   (new_sample),
        .carrier_i    (carrier_i),
        .bit_data     (bit_data),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bit_valid = 1'b0;
        new_sample = 1'b0;
        en = 1'b1;
        carrier_i = 16'sd16384;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_bit(input logic b);
        bit_valid = 1'b1;
        bit_data  = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic strobe(input string tag, input int exp_s, input int exp_u);
        new_sample = 1'b1;
        tick();
        new_sample = 1'b0;
        check({tag, "_valid"}, int'(sample_valid), 1);
        check({tag, "_sample"}, int'(sample), exp_s);
        check({tag, "_underrun"}, int'(underrun), exp_u);
        $display("strobe %s: sample=%0d valid=%0b underrun=%0b", tag, sample, sample_valid, underrun);
    endtask

    initial begin
        logic [4:0] t2_bits;
        logic [2:0] t6_bits;
        logic [2:0] t6_neg;
        int exp_s;

        // Reset state
        tick();
        check("rst_sample", int'(sample), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(bit_ready), 1);
        do_reset();

        // 1: bits 0,1, strobe every 6 clocks
        push_bit(1'b0);
        push_bit(1'b1);
        for (int k = 1; k <= 14; k++) begin
            if (k == 1 || k == 14) exp_s = 0;
            else if (k <= 7)       exp_s = 16384;
            else                   exp_s = -16384;
            strobe($sformatf("t1_s%0d", k), exp_s, (k == 13) ? 1 : 0);
            if (k == 1)  check("t1_busy_on", int'(busy), 1);
            if (k == 13) check("t1_busy_off", int'(busy), 0);
            tick();
            check($sformatf("t1_gap%0d_valid", k), int'(sample_valid), 0);
            check($sformatf("t1_gap%0d_hold", k), int'(sample), exp_s);
            repeat (4) tick();
        end

        // 2: five back-to-back pushes with no strobes
        do_reset();
        t2_bits = 5'b10110; // b0=0 b1=1 b2=1 b3=0 b4=1
        bit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit_data = t2_bits[i];
            check($sformatf("t2_ready%0d", i), int'(bit_ready), 1);
            tick();
        end
        check("t2_full", int'(bit_ready), 0);
        bit_data = t2_bits[4];
        tick();
        tick();
        check("t2_still_full", int'(bit_ready), 0);
        strobe("t2_pop", 0, 0);
        check("t2_space", int'(bit_ready), 1);
        tick();
        bit_valid = 1'b0;
        check("t2_refull", int'(bit_ready), 0);
        for (int s = 0; s < 5; s++) begin
            for (int j = 0; j < 6; j++) begin
                strobe($sformatf("t2_sym%0d_%0d", s, j), t2_bits[s] ? -16384 : 16384,
                       (s == 4 && j == 5) ? 1 : 0);
            end
        end

        // 3: saturating negation at the extremes
        do_reset();
        push_bit(1'b1);
        strobe("t3_load", 0, 0);
        carrier_i = -16'sd32768;
        strobe("t3_min", 32767, 0);
        carrier_i = 16'sd32767;
        strobe("t3_max", -32767, 0);

        // 4: en=0 freezes the symbol in progress
        do_reset();
        push_bit(1'b0);
        strobe("t4_load", 0, 0);
        for (int j = 0; j < 3; j++) strobe($sformatf("t4_pre%0d", j), 16384, 0);
        en = 1'b0;
        carrier_i = 16'sd1000;
        new_sample = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("t4_frz%0d_valid", j), int'(sample_valid), 0);
            check($sformatf("t4_frz%0d_hold", j), int'(sample), 16384);
        end
        new_sample = 1'b0;
        check("t4_frz_busy", int'(busy), 1);
        en = 1'b1;
        carrier_i = 16'sd16384;
        for (int j = 0; j < 3; j++) strobe($sformatf("t4_post%0d", j), 16384, (j == 2) ? 1 : 0);
        check("t4_idle", int'(busy), 0);

        // 5: asynchronous reset between clock edges
        do_reset();
        push_bit(1'b0);
        push_bit(1'b1);
        strobe("t5_load", 0, 0);
        strobe("t5_s1", 16384, 0);
        strobe("t5_s2", 16384, 0);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_sample", int'(sample), 0);
        check("t5_rst_valid", int'(sample_valid), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_ready", int'(bit_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        strobe("t5_after", 0, 0);
        check("t5_fifo_empty", int'(busy), 0);

        // 6: bits 1,1,0 with or without differential encoding
        do_reset();
        t6_bits = 3'b011; // 1,1,0
`ifdef BPSK_DIFF_ENCODE_EN
        t6_neg = 3'b001;  // signs -, +, +
`else
        t6_neg = 3'b011;  // signs -, -, +
`endif
        for (int i = 0; i < 3; i++) push_bit(t6_bits[i]);
        strobe("t6_load", 0, 0);
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 6; j++) begin
                strobe($sformatf("t6_sym%0d_%0d", s, j), t6_neg[s] ? -16384 : 16384,
                       (s == 2 && j == 5) ? 1 : 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
